sprite_sequencer: RTL and testbench

SPRITE_SEQUENCER -- requirements
Module: sprite_sequencer

---
 rtl/sprite_sequencer_if.sv | 27 ++
 rtl/sprite_sequencer.sv | 154 +++++++++++++++
 tb/tb_sprite_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_sequencer_if.sv
// Request/handshake and datapath-control bundle between a sprite client and the sequencer.
interface sprite_sequencer_if;
    logic       go;
    logic [7:0] x_new;
    logic [6:0] y_new;
    logic [2:0] colour_new;
    logic       load_x;
    logic       load_y;
    logic       draw;
    logic       erase;
    logic       plot;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [2:0] colour;
    logic       busy;
    logic       done;

    modport master (
        output go, x_new, y_new, colour_new,
        input  load_x, load_y, draw, erase, plot, x_pos, y_pos, colour, busy, done
    );

    modport slave (
        input  go, x_new, y_new, colour_new,
        output load_x, load_y, draw, erase, plot, x_pos, y_pos, colour, busy, done
    );
endinterface

// File: rtl/sprite_sequencer.sv
// Sprite move sequencer: erases the 4x4 sprite at its old origin, draws it at the new
// (clamped) origin, then holds for one frame before accepting another request.
module sprite_sequencer #(
    parameter int unsigned FRAME_TICKS = 833333,
    parameter int unsigned MAX_X       = 156,
    parameter int unsigned MAX_Y       = 116
) (
    input  logic               clock,
    input  logic               reset,
    sprite_sequencer_if.slave  bus
);

    localparam int unsigned HoldW    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(FRAME_TICKS - 1);
    localparam logic [7:0]       MaxXV    = 8'(MAX_X);
    localparam logic [6:0]       MaxYV    = 7'(MAX_Y);

    typedef enum logic [2:0] {
        StIdle, StLoadOld, StErase, StLoadNew, StDraw, StHold
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             drawn_q, drawn_d;
    logic             done_q, done_d;
    logic [7:0]       px_q, px_d, x_q, x_d;
    logic [6:0]       py_q, py_d, y_q, y_d;
    logic [2:0]       pc_q, pc_d, c_q, c_d;
    logic [7:0]       x_clamp;
    logic [6:0]       y_clamp;
    logic             load, draw, erase, busy;

    assign x_clamp = (bus.x_new > MaxXV) ? MaxXV : bus.x_new;
    assign y_clamp = (bus.y_new > MaxYV) ? MaxYV : bus.y_new;

    // State and datapath registers; reset wipes everything so outputs are 0 immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            drawn_q <= 1'b0;
            done_q  <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            pc_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            drawn_q <= drawn_d;
            done_q  <= done_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pc_q    <= pc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
        end
    end

    // Next-state logic and decoded datapath controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        drawn_d = drawn_q;
        done_d  = 1'b0;
        px_d    = px_q;
        py_d    = py_q;
        pc_d    = pc_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        load    = 1'b0;
        draw    = 1'b0;
        erase   = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy   = 1'b0;
                cnt_d  = '0;
                hold_d = '0;
                if (bus.go) begin
                    px_d = x_clamp;
                    py_d = y_clamp;
                    pc_d = bus.colour_new;
                    if (drawn_q) begin
                        state_d = StLoadOld;
                    end else begin
                        // Skipping the erase leg: the new origin is presented on LOAD_NEW entry.
                        state_d = StLoadNew;
                        x_d     = x_clamp;
                        y_d     = y_clamp;
                        c_d     = bus.colour_new;
                    end
                end
            end
            StLoadOld: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = StErase;
            end
            StErase: begin
                erase = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StLoadNew;
                    x_d     = px_q;
                    y_d     = py_q;
                    c_d     = pc_q;
                end
            end
            StLoadNew: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = StDraw;
            end
            StDraw: begin
                draw  = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StHold;
                    drawn_d = 1'b1;
                    hold_d  = '0;
                end
            end
            StHold: begin
                hold_d = hold_q + HoldW'(1);
                if (hold_q == HoldLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.load_x = load;
    assign bus.load_y = load;
    assign bus.draw   = draw;
    assign bus.erase  = erase;
    assign bus.plot   = draw | erase;
    assign bus.x_pos  = x_q;
    assign bus.y_pos  = y_q;
    assign bus.colour = c_q;
    assign bus.busy   = busy;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_sprite_sequencer.sv
// Directed bench for sprite_sequencer with a 4-cycle frame hold.
module tb_sprite_sequencer;

    localparam int unsigned FT = 4;

    // Control vector order: {load_x, load_y, draw, erase, plot, busy, done}
    localparam logic [6:0] CtlLoad  = 7'b1100010;
    localparam logic [6:0] CtlErase = 7'b0001110;
    localparam logic [6:0] CtlDraw  = 7'b0010110;
    localparam logic [6:0] CtlHold  = 7'b0000010;
    localparam logic [6:0] CtlDone  = 7'b0000001;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    sprite_sequencer_if sif ();

    sprite_sequencer #(
        .FRAME_TICKS (FT),
        .MAX_X       (156),
        .MAX_Y       (116)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [24:0] observe();
        return {sif.load_x, sif.load_y, sif.draw, sif.erase, sif.plot, sif.busy, sif.done,
                sif.x_pos, sif.y_pos, sif.colour};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one request from IDLE and follows every cycle of the sequence through to done.
    task automatic do_move(input logic [7:0] xn, input logic [6:0] yn, input logic [2:0] cn,
                           input bit exp_erase, input logic [7:0] ox, input logic [6:0] oy,
                           input logic [2:0] oc, input logic [7:0] ex, input logic [6:0] ey,
                           input bit keep_go, input string tag);
        logic [24:0] exp_v;
        checks++;
        if (sif.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_busy got=%b exp=0", tag, sif.busy);
        end
        sif.x_new = xn;
        sif.y_new = yn;
        sif.colour_new = cn;
        sif.go = 1'b1;
        step();
        if (!keep_go) sif.go = 1'b0;
        if (exp_erase) begin
            exp_v = {CtlLoad, ox, oy, oc};
            checks++;
            if (observe() !== exp_v) begin
                failures++;
                $display("FAIL %s load_old got=%h exp=%h", tag, observe(), exp_v);
            end
            step();
            for (int i = 0; i < 16; i++) begin
                exp_v = {CtlErase, ox, oy, oc};
                checks++;
                if (observe() !== exp_v) begin
                    failures++;
                    $display("FAIL %s erase[%0d] got=%h exp=%h", tag, i, observe(), exp_v);
                end
                step();
            end
        end
        exp_v = {CtlLoad, ex, ey, cn};
        checks++;
        if (observe() !== exp_v) begin
            failures++;
            $display("FAIL %s load_new got=%h exp=%h", tag, observe(), exp_v);
        end
        step();
        for (int i = 0; i < 16; i++) begin
            exp_v = {CtlDraw, ex, ey, cn};
            checks++;
            if (observe() !== exp_v) begin
                failures++;
                $display("FAIL %s draw[%0d] got=%h exp=%h", tag, i, observe(), exp_v);
            end
            step();
        end
        for (int i = 0; i < int'(FT); i++) begin
            exp_v = {CtlHold, ex, ey, cn};
            checks++;
            if (observe() !== exp_v) begin
                failures++;
                $display("FAIL %s hold[%0d] got=%h exp=%h", tag, i, observe(), exp_v);
            end
            step();
        end
        exp_v = {CtlDone, ex, ey, cn};
        checks++;
        if (observe() !== exp_v) begin
            failures++;
            $display("FAIL %s done got=%h exp=%h", tag, observe(), exp_v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.go = 1'b0;
        sif.x_new = '0;
        sif.y_new = '0;
        sif.colour_new = '0;
        step();
        step();
        checks++;
        if (observe() !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", observe());
        end
        reset = 1'b0;
        step();
        checks++;
        if (observe() !== 25'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0", observe());
        end
    endtask

    task automatic test_first_move();
        do_move(8'd10, 7'd20, 3'b100, 1'b0, 8'd0, 7'd0, 3'd0, 8'd10, 7'd20, 1'b0, "first");
        step();
        checks++;
        if (sif.done !== 1'b0) begin
            failures++;
            $display("FAIL first done_width got=%b exp=0", sif.done);
        end
    endtask

    task automatic test_second_move();
        do_move(8'd11, 7'd20, 3'b100, 1'b1, 8'd10, 7'd20, 3'b100, 8'd11, 7'd20, 1'b0, "second");
        step();
    endtask

    task automatic test_clamp();
        do_move(8'd200, 7'd127, 3'b010, 1'b1, 8'd11, 7'd20, 3'b100, 8'd156, 7'd116, 1'b0, "clamp");
        step();
    endtask

    task automatic test_same_origin();
        do_move(8'd255, 7'd120, 3'b011, 1'b1, 8'd156, 7'd116, 3'b010, 8'd156, 7'd116, 1'b0,
                "same");
        step();
    endtask

    task automatic test_ignored_go();
        do_move(8'd30, 7'd40, 3'b001, 1'b1, 8'd156, 7'd116, 3'b011, 8'd30, 7'd40, 1'b1, "held1");
        // go stayed high; the done cycle itself accepts the next request.
        do_move(8'd31, 7'd41, 3'b101, 1'b1, 8'd30, 7'd40, 3'b001, 8'd31, 7'd41, 1'b0, "held2");
        step();
    endtask

    task automatic test_reset_mid();
        int guard;
        sif.x_new = 8'd50;
        sif.y_new = 7'd60;
        sif.colour_new = 3'b110;
        sif.go = 1'b1;
        step();
        sif.go = 1'b0;
        guard = 0;
        while (sif.draw !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (sif.draw !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid reach_draw got=%b exp=1", sif.draw);
        end
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        #1;
        checks++;
        if (observe() !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid async got=%h exp=0", observe());
        end
        step();
        checks++;
        if (observe() !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid held got=%h exp=0", observe());
        end
        reset = 1'b0;
        step();
        do_move(8'd5, 7'd6, 3'b111, 1'b0, 8'd0, 7'd0, 3'd0, 8'd5, 7'd6, 1'b0, "after_reset");
        step();
    endtask

    task automatic test_random();
        logic [7:0] xn;
        logic [6:0] yn;
        logic [7:0] xe;
        logic [6:0] ye;
        int plots;
        int overlap;
        int guard;
        bit drawn_m;
        drawn_m = 1'b1;
        for (int n = 0; n < 100; n++) begin
            xn = 8'($urandom_range(0, 255));
            yn = 7'($urandom_range(0, 127));
            xe = (xn > 8'd156) ? 8'd156 : xn;
            ye = (yn > 7'd116) ? 7'd116 : yn;
            sif.x_new = xn;
            sif.y_new = yn;
            sif.colour_new = 3'($urandom_range(0, 7));
            sif.go = 1'b1;
            step();
            sif.go = 1'b0;
            plots = 0;
            overlap = 0;
            guard = 0;
            while (sif.done !== 1'b1 && guard < 100) begin
                if (sif.plot === 1'b1) plots++;
                if ((sif.draw & sif.erase) === 1'b1) overlap++;
                step();
                guard++;
            end
            checks++;
            if (sif.done !== 1'b1 || overlap != 0 || plots != (drawn_m ? 32 : 16) ||
                sif.x_pos !== xe || sif.y_pos !== ye) begin
                failures++;
                $display("FAIL random[%0d] done=%b overlap=%0d plots=%0d pos=%0d,%0d exp plots=%0d pos=%0d,%0d",
                         n, sif.done, overlap, plots, sif.x_pos, sif.y_pos,
                         drawn_m ? 32 : 16, xe, ye);
            end
            drawn_m = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_first_move();
        test_second_move();
        test_clamp();
        test_same_origin();
        test_ignored_go();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
